// File: rtl/viterbi_hd_k3.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3 (g0=111, g1=101).
// Four-state ACS with register-exchange survivors, serial decoded output,
// and a flush mode that drains the survivor tail at the end of a frame.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | accept symbols, emit decided bits once the window is full
// ST_FLUSH | emit latched survivor bits oldest first, ignore inputs
module viterbi_hd_k3 #(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] sym_i,
   input  logic       sym_valid_i,
   input  logic       flush_i,
   output logic       data_serial_o,
   output logic       valid_serial_o,
   output logic       busy_o
);

   localparam int CNT_W = $clog2(TB_DEPTH + 1);
   localparam int IDX_W = $clog2(TB_DEPTH);
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;
   localparam logic [PM_W-1:0]  PM_INIT  = PM_W'(8);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TB_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);

   logic [0:0]          st;
   logic [PM_W-1:0]     pm [4];
   logic [TB_DEPTH-1:0] surv [4];
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    rem;
   logic [TB_DEPTH-1:0] fl_surv;

   logic [PM_W-1:0]     pm_new [4];
   logic [TB_DEPTH-1:0] surv_new [4];
   logic [PM_W-1:0]     eff_pm [4];
   logic [TB_DEPTH-1:0] eff_surv [4];
   logic [1:0]          best;
   logic [PM_W-1:0]     best_pm;
   logic [CNT_W-1:0]    cnt_eff;
   logic [CNT_W-1:0]    rem_entry;
   logic                accept;
   logic                run_emit;
   logic [IDX_W-1:0]    fl_idx;

   // Hamming distance between the received symbol and the branch output
   function automatic logic [1:0] branch_metric(input logic [1:0] s, input logic u,
                                                input logic [1:0] sym);
      logic [1:0] diff;
      diff = {u ^ s[1] ^ s[0], u ^ s[0]} ^ sym;
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

   // Add-compare-select for all four states, with MSB-clear normalisation
   always_comb begin
      logic [1:0]      nsv, p0, p1;
      logic            u;
      logic [PM_W-1:0] cand0, cand1;
      logic            all_msb;
      all_msb = 1'b1;
      nsv = '0; p0 = '0; p1 = '0; u = 1'b0; cand0 = '0; cand1 = '0;
      for (int ns = 0; ns < 4; ns++) begin
         nsv   = 2'(ns);
         p0    = {nsv[0], 1'b0};
         p1    = {nsv[0], 1'b1};
         u     = nsv[1];
         cand0 = pm[p0] + PM_W'(branch_metric(p0, u, sym_i));
         cand1 = pm[p1] + PM_W'(branch_metric(p1, u, sym_i));
         // Ties go to the predecessor whose low state bit is 0
         if (cand1 < cand0) begin
            pm_new[ns]   = cand1;
            surv_new[ns] = {surv[p1][TB_DEPTH-2:0], u};
         end else begin
            pm_new[ns]   = cand0;
            surv_new[ns] = {surv[p0][TB_DEPTH-2:0], u};
         end
         all_msb = all_msb & pm_new[ns][PM_W-1];
      end
      if (all_msb) begin
         for (int ns = 0; ns < 4; ns++) pm_new[ns][PM_W-1] = 1'b0;
      end
   end

   // Best-state search over the metrics that will be current after this edge
   always_comb begin
      accept = sym_valid_i && (st == ST_RUN);
      for (int i = 0; i < 4; i++) begin
         eff_pm[i]   = accept ? pm_new[i]   : pm[i];
         eff_surv[i] = accept ? surv_new[i] : surv[i];
      end
      best    = 2'd0;
      best_pm = eff_pm[0];
      for (int i = 1; i < 4; i++) begin
         if (eff_pm[i] < best_pm) begin
            best    = 2'(i);
            best_pm = eff_pm[i];
         end
      end
      cnt_eff   = (accept && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
      rem_entry = (cnt_eff >= CNT_LAST) ? CNT_LAST : cnt_eff;
      run_emit  = accept && (cnt >= CNT_LAST);
      fl_idx    = IDX_W'(rem - 1'b1);
   end

   // Decoder state, survivors and registered serial outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st             <= ST_RUN;
         cnt            <= '0;
         rem            <= '0;
         fl_surv        <= '0;
         data_serial_o  <= 1'b0;
         valid_serial_o <= 1'b0;
         busy_o         <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            pm[i]   <= (i == 0) ? '0 : PM_INIT;
            surv[i] <= '0;
         end
      end else begin
         data_serial_o  <= 1'b0;
         valid_serial_o <= 1'b0;
         busy_o         <= 1'b0;
         case (st)
            ST_RUN: begin
               if (accept) begin
                  cnt <= cnt_eff;
                  for (int i = 0; i < 4; i++) begin
                     pm[i]   <= pm_new[i];
                     surv[i] <= surv_new[i];
                  end
                  if (run_emit) begin
                     valid_serial_o <= 1'b1;
                     data_serial_o  <= surv_new[best][TB_DEPTH-1];
                  end
               end
               if (flush_i) begin
                  if (rem_entry == '0) begin
                     cnt <= '0;
                     for (int i = 0; i < 4; i++) begin
                        pm[i]   <= (i == 0) ? '0 : PM_INIT;
                        surv[i] <= '0;
                     end
                  end else begin
                     st      <= ST_FLUSH;
                     rem     <= rem_entry;
                     fl_surv <= eff_surv[best];
                  end
               end
            end
            default: begin
               valid_serial_o <= 1'b1;
               busy_o         <= 1'b1;
               data_serial_o  <= fl_surv[fl_idx];
               rem            <= rem - 1'b1;
               if (rem == CNT_W'(1)) begin
                  st  <= ST_RUN;
                  cnt <= '0;
                  for (int i = 0; i < 4; i++) begin
                     pm[i]   <= (i == 0) ? '0 : PM_INIT;
                     surv[i] <= '0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_hd_k3.sv
// Directed bench for viterbi_hd_k3: a PM_W=6 and a PM_W=5 instance share
// the same stimulus; decoded streams are compared against the source bits.
module tb_viterbi_hd_k3;

   typedef logic [1:0] sym_q_t[$];
   typedef bit         bit_q_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] sym = 2'b00;
   logic       sym_valid = 1'b0;
   logic       flush = 1'b0;
   logic       d6, v6, b6, d5, v5, b5;

   viterbi_hd_k3 #(.TB_DEPTH(16), .PM_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .sym_i(sym), .sym_valid_i(sym_valid), .flush_i(flush),
      .data_serial_o(d6), .valid_serial_o(v6), .busy_o(b6));

   viterbi_hd_k3 #(.TB_DEPTH(16), .PM_W(5)) dut_n5 (
      .clk(clk), .rst_n(rst_n), .sym_i(sym), .sym_valid_i(sym_valid), .flush_i(flush),
      .data_serial_o(d5), .valid_serial_o(v5), .busy_o(b5));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge
   bit_q_t q6, q5;
   int busy6 = 0, busy5 = 0;
   int edge_n = 0;
   int first_edge = -1;
   int exp_first = -1;
   int last_acc = 0;

   always @(posedge clk) edge_n++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (v6) begin
            if (first_edge < 0) first_edge = edge_n;
            q6.push_back(d6);
         end
         if (v5) q5.push_back(d5);
         if (b6) busy6++;
         if (b5) busy5++;
      end
   end

   task automatic clear_mon();
      q6.delete();
      q5.delete();
      busy6 = 0;
      busy5 = 0;
      first_edge = -1;
   endtask

   task automatic drive(input logic [1:0] s, input logic v, input logic f);
      @(posedge clk);
      #2;
      sym = s;
      sym_valid = v;
      flush = f;
   endtask

   function automatic sym_q_t encode(input bit_q_t bits);
      sym_q_t     out;
      logic [1:0] s;
      logic       u;
      s = 2'b00;
      foreach (bits[i]) begin
         u = bits[i];
         out.push_back({u ^ s[1] ^ s[0], u ^ s[0]});
         s = {u, s[1]};
      end
      return out;
   endfunction

   task automatic run_frame(input sym_q_t syms);
      clear_mon();
      for (int i = 0; i < syms.size(); i++) begin
         drive(syms[i], 1'b1, 1'b0);
         if (i == 15) exp_first = edge_n + 1;
         last_acc = edge_n + 1;
      end
      drive(2'b00, 1'b0, 1'b1);
      drive(2'b00, 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      #2;
   endtask

   task automatic check_bits(input string tag, input bit_q_t got, input bit_q_t exp);
      logic g;
      check({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         g = (i < got.size()) ? logic'(got[i]) : 1'bx;
         check($sformatf("%s[%0d]", tag, i), {31'd0, g}, {31'd0, exp[i]});
      end
   endtask

   sym_q_t clean_syms, err_syms, short_syms, stream_syms, noisy_syms;
   bit_q_t clean_bits, short_bits, stream_bits, noisy_bits;
   logic [7:0] byte_v;

   initial begin
      clean_syms = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
      clean_bits = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
      short_syms = '{2'b11, 2'b10, 2'b00};
      short_bits = '{1, 0, 1};
      err_syms = clean_syms;
      err_syms[4] = 2'b01;

      // Reset values, asserted and just after release
      #12;
      check("rst_valid", v6, 0);
      check("rst_data", d6, 0);
      check("rst_busy", b6, 0);
      check("rst_valid_n5", v5, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      check("post_rst_valid", v6, 0);

      // Clean frame: nothing during RUN, ten flush bits, byte 0xA5
      run_frame(clean_syms);
      check_bits("clean", q6, clean_bits);
      check_bits("clean_n5", q5, clean_bits);
      check("clean_busy", busy6, 10);
      check("clean_first_valid_edge", first_edge, last_acc + 2);
      byte_v = '0;
      for (int i = 0; i < 8; i++) byte_v[i] = (i < q6.size()) ? q6[i] : 1'b0;
      check("deser_byte", byte_v, 8'hA5);

      // Single channel error in symbol 4
      run_frame(err_syms);
      check_bits("err1", q6, clean_bits);

      // Short frame, then a full frame from state 0
      run_frame(short_syms);
      check_bits("short", q6, short_bits);
      check("short_busy", busy6, 3);
      run_frame(clean_syms);
      check_bits("after_short", q6, clean_bits);

      // Steady error-free stream: 40 random bits + two zero tail bits
      stream_bits.delete();
      for (int i = 0; i < 40; i++) stream_bits.push_back(bit'($urandom_range(0, 1)));
      stream_bits.push_back(0);
      stream_bits.push_back(0);
      stream_syms = encode(stream_bits);
      run_frame(stream_syms);
      check("stream_first_valid_edge", first_edge, exp_first);
      check_bits("stream", q6, stream_bits);
      check_bits("stream_n5", q5, stream_bits);
      check("stream_busy", busy6, 15);

      // Long stream with sparse single errors: metrics climb past the
      // narrow instance's MSB, so its decisions rely on normalisation
      noisy_bits.delete();
      for (int i = 0; i < 200; i++) noisy_bits.push_back(bit'($urandom_range(0, 1)));
      noisy_bits.push_back(0);
      noisy_bits.push_back(0);
      noisy_syms = encode(noisy_bits);
      for (int k = 0; k < 19; k++) noisy_syms[5 + 10 * k][1] = ~noisy_syms[5 + 10 * k][1];
      run_frame(noisy_syms);
      check_bits("noisy", q6, noisy_bits);
      check_bits("noisy_n5", q5, noisy_bits);

      // Flush together with the last symbol, then reset in the middle of FLUSH
      clear_mon();
      drive(2'b11, 1'b1, 1'b0);
      drive(2'b10, 1'b1, 1'b0);
      drive(2'b00, 1'b1, 1'b1);
      drive(2'b00, 1'b0, 1'b0);
      check("flsym_entry_valid", v6, 0);
      @(posedge clk);
      #2;
      check("flsym_bit0_valid", v6, 1);
      check("flsym_bit0_data", d6, 1);
      check("flsym_bit0_busy", b6, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", v6, 0);
      check("midrst_data", d6, 0);
      check("midrst_busy", b6, 0);
      check("midrst_valid_n5", v5, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      check("midrst_no_more_bits", q6.size(), 0);
      run_frame(clean_syms);
      check_bits("after_rst", q6, clean_bits);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
